// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl
//   Memory-side endpoint behind the memory arbiter. Each accepted request is
//   issued to a single-port synchronous SRAM (1-cycle read latency) in its
//   accept cycle. Exactly one in-order response per request comes back
//   through a response FIFO: read data for reads, zero for write acks.
//   A credit count (in-flight access + queued responses) throttles req_ready
//   so SRAM read data always has a FIFO slot, even under response backpressure.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   req_valid/ready  request handshake; req_addr (byte address), req_we,
//                    req_wdata, req_be (write byte enables)
//   resp_valid/ready response handshake; resp_data (read data, 0 for writes)
//   sram_en/we/be    SRAM strobe, write enable, byte enables
//   sram_addr        SRAM word address
//   sram_wdata       SRAM write data
//   sram_rdata       SRAM read data, valid the cycle after a read strobe
module mem_sram_ctrl #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int SRAM_ADDR_WIDTH = 16,
    parameter int RESP_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic                       req_we,
    input  logic [DATA_WIDTH-1:0]      req_wdata,
    input  logic [DATA_WIDTH/8-1:0]    req_be,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [DATA_WIDTH-1:0]      resp_data,
    output logic                       sram_en,
    output logic                       sram_we,
    output logic [DATA_WIDTH/8-1:0]    sram_be,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0]      sram_wdata,
    input  logic [DATA_WIDTH-1:0]      sram_rdata
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int WOFF  = $clog2(BE_W);
    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    logic                  req_fire;
    logic                  inflight;
    logic                  inflight_we;
    logic [CNT_W-1:0]      fifo_count;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W:0]        occ;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];

    // Upper address bits alias by wrap-around and byte-offset bits are
    // ignored; both groups are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr;

    // ---- stage p0: accept and drive the SRAM in the fire cycle ----
    // Occupancy uses the registered count, so a pop only frees its credit
    // on the following cycle.
    assign occ       = {1'b0, fifo_count} + (CNT_W + 1)'(inflight);
    assign req_ready = !rst && (occ < (CNT_W + 1)'(RESP_DEPTH));
    assign req_fire  = req_valid && req_ready;

    assign sram_en    = req_fire;
    assign sram_we    = req_fire && req_we;
    assign sram_be    = (req_fire && req_we) ? req_be : '0;
    assign sram_addr  = req_addr[SRAM_ADDR_WIDTH+WOFF-1 -: SRAM_ADDR_WIDTH];
    assign sram_wdata = req_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= req_fire;
        end
        inflight_we <= req_we;
    end

    // ---- stage p1: SRAM data returns, captured into the response FIFO ----
    assign push      = inflight;
    assign push_data = inflight_we ? '0 : sram_rdata;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    // ---- stage p2: response FIFO head drives the response port ----
    assign resp_valid = (fifo_count != '0) && !rst;
    assign resp_data  = resp_valid ? fifo_mem[rd_ptr] : '0;
    assign pop        = resp_valid && resp_ready;

    // Pointers wrap explicitly so non-power-of-2 depths work.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // The credit scheme must make a push into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && fifo_count == CNT_W'(RESP_DEPTH)));
        end
    end

endmodule
